// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CHK,
        LAST,
        DONE,
        ERROR
    } loader_state_e;

    // States in which the loader is willing to take a stream byte
    function automatic logic accepts_byte(input loader_state_e s);
        return s inside {LEN_LO, LEN_HI, DATA, CHK};
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Stream-in / imem-out / status bundle for the instruction loader.
// master = byte source and memory/core side, slave = the loader itself.
interface inst_loader_if #(
    parameter int ADDR_W = 8
);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
    );

endinterface

// File: rtl/word_assembler.sv
// Collects little-endian bytes into 32-bit words. The completed word and its
// valid pulse are presented combinationally with the 4th byte so the parent
// can register them on the same edge the byte is accepted.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word_out
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;

    // Byte position counter and shift register of the first three bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else if (clear) begin
            byte_cnt_q <= '0;
        end else if (byte_valid) begin
            byte_cnt_q <= (byte_cnt_q == LAST_BYTE) ? 2'd0 : byte_cnt_q + 2'd1;
            shift_q    <= {byte_in, shift_q[23:8]};
        end
    end

    assign word_valid = byte_valid && !clear && (byte_cnt_q == LAST_BYTE);
    assign word_out   = {byte_in, shift_q};

endmodule

// File: rtl/inst_loader.sv
// Boot-time program loader: receives a length-prefixed byte image, writes it
// to instruction memory from word 0 upward and releases the core when done.
// Optional trailing checksum byte enabled by defining INST_LOADER_CHKSUM_EN.
module inst_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input logic         clk,
    input logic         reset,
    inst_loader_if.slave bus
);

    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);

    loader_state_e     state_q, state_d;
    logic              payload_done_q, payload_done_d;
    logic [7:0]        len_lo_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_cnt_q;
    logic              rx_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              core_reset_q;
    logic              done_q;
    logic              error_q;
    logic              xfer;
    logic              data_byte;
    logic              word_valid;
    logic [31:0]       word;
    logic              last_word;
    logic [LEN_W-1:0]  len_in;
`ifdef INST_LOADER_CHKSUM_EN
    logic [7:0]        sum_q;
    logic              chk_ok_q;
`endif

    assign xfer      = bus.rx_valid && rx_ready_q;
    assign data_byte = xfer && (state_q == DATA);
    assign last_word = (word_cnt_q == len_q - LEN_W'(1));
    assign len_in    = {bus.rx_data, len_lo_q};

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q != DATA),
        .byte_valid(data_byte),
        .byte_in   (bus.rx_data),
        .word_valid(word_valid),
        .word_out  (word)
    );

    // State register; payload_done marks the drain cycle while the last write commits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= LEN_LO;
            payload_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            payload_done_q <= payload_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        payload_done_d = payload_done_q;
        case (state_q)
            LEN_LO: if (xfer) state_d = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if ({1'b0, len_in} > MAX_WORDS) begin
                        state_d = ERROR;
                    end else if (len_in == '0) begin
`ifdef INST_LOADER_CHKSUM_EN
                        state_d = CHK;
`else
                        state_d = LAST;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (payload_done_q) begin
                    payload_done_d = 1'b0;
`ifdef INST_LOADER_CHKSUM_EN
                    state_d = CHK;
`else
                    state_d = LAST;
`endif
                end else if (word_valid && last_word) begin
                    payload_done_d = 1'b1;
                end
            end
`ifdef INST_LOADER_CHKSUM_EN
            CHK:  if (xfer) state_d = LAST;
            LAST: state_d = chk_ok_q ? DONE : ERROR;
`else
            LAST: state_d = DONE;
`endif
            default: state_d = state_q;
        endcase
    end

    // Capture the 16-bit word count from the two header bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo_q <= '0;
            len_q    <= '0;
        end else if (xfer) begin
            if (state_q == LEN_LO) len_lo_q <= bus.rx_data;
            if (state_q == LEN_HI) len_q    <= len_in;
        end
    end

    // Write register, word counter and post-write address increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we_q    <= 1'b0;
            imem_wdata_q <= '0;
            imem_addr_q  <= '0;
            word_cnt_q   <= '0;
        end else begin
            imem_we_q <= word_valid;
            if (word_valid) begin
                imem_wdata_q <= word;
                word_cnt_q   <= word_cnt_q + LEN_W'(1);
            end
            if (imem_we_q) imem_addr_q <= imem_addr_q + ADDR_W'(1);
        end
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready_q   <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            rx_ready_q   <= accepts_byte(state_d) && !payload_done_d;
            core_reset_q <= (state_d != DONE);
            done_q       <= (state_d == DONE);
            error_q      <= (state_d == ERROR);
        end
    end

`ifdef INST_LOADER_CHKSUM_EN
    // Running mod-256 sum of payload bytes and result of the trailing compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q    <= '0;
            chk_ok_q <= 1'b0;
        end else begin
            if (data_byte) sum_q <= sum_q + bus.rx_data;
            if (xfer && (state_q == CHK)) chk_ok_q <= (bus.rx_data == sum_q);
        end
    end
`endif

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.core_reset = core_reset_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with hand-computed expected writes.
// Checksum cases are built when INST_LOADER_CHKSUM_EN is defined.
module tb_inst_loader;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic reset;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [7:0]  wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          last_we_cycle;
    int          done_cycle;

    byte_q_t basic_stream;
    byte_q_t stream;

    inst_loader_if #(.ADDR_W(8)) bus ();

    inst_loader #(.ADDR_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Cycle counter used to measure write-to-done latency
    always @(posedge clk) cyc++;

    // Write and completion monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            wr_addr_log.delete();
            wr_data_log.delete();
            last_we_cycle = -1;
            done_cycle    = -1;
        end else begin
            if (bus.imem_we) begin
                wr_addr_log.push_back(bus.imem_addr);
                wr_data_log.push_back(bus.imem_wdata);
                last_we_cycle = cyc;
            end
            if (bus.done && done_cycle < 0) done_cycle = cyc;
        end
    end

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Send bytes over the handshake; gapped drops rx_valid for a cycle between bytes
    task automatic applyStimulus(input byte_q_t bytes, input bit gapped);
        for (int i = 0; i < bytes.size(); i++) begin
            int guard = 0;
            bus.rx_data  = bytes[i];
            bus.rx_valid = 1'b1;
            while (!bus.rx_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.rx_ready) begin
                checkOutput("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
                bus.rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
            bus.rx_valid = 1'b0;
            if (gapped) @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    // Bounded wait for done or error
    task automatic waitTerminal();
        int guard = 0;
        while (!(bus.done || bus.error) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (!(bus.done || bus.error)) checkOutput("terminal_timeout", 32'(bus.done), 32'd1);
    endtask

    // Pulse reset for two cycles and leave the loader ready for a byte
    task automatic doReset();
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Compare the logged writes against the two-word basic image
    task automatic checkBasicWrites(input string tag);
        checkOutput({tag, "_nwrites"}, 32'(wr_data_log.size()), 32'd2);
        checkOutput({tag, "_addr0"}, 32'(wr_addr_log[0]), 32'd0);
        checkOutput({tag, "_data0"}, wr_data_log[0], 32'h00500093);
        checkOutput({tag, "_addr1"}, 32'(wr_addr_log[1]), 32'd1);
        checkOutput({tag, "_data1"}, wr_data_log[1], 32'h00100113);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b0;
        #1 reset = 1'b1;
`ifdef INST_LOADER_CHKSUM_EN
        basic_stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h07};
`else
        basic_stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
`endif

        // Reset values
        @(negedge clk);
        #1;
        checkOutput("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("rst_core_reset", 32'(bus.core_reset), 32'd1);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_error", 32'(bus.error), 32'd0);
        checkOutput("rst_imem_we", 32'(bus.imem_we), 32'd0);
        checkOutput("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("rst_imem_wdata", bus.imem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(bus.rx_ready), 32'd1);

        // Basic two-word load
        applyStimulus(basic_stream, 1'b0);
        waitTerminal();
        checkBasicWrites("basic");
        checkOutput("basic_done", 32'(bus.done), 32'd1);
        checkOutput("basic_core_reset", 32'(bus.core_reset), 32'd0);
        checkOutput("basic_error", 32'(bus.error), 32'd0);
        checkOutput("basic_rx_ready", 32'(bus.rx_ready), 32'd0);
`ifndef INST_LOADER_CHKSUM_EN
        checkOutput("basic_we_to_done", 32'(done_cycle - last_we_cycle), 32'd2);
`endif

        // DONE is terminal: offered bytes are ignored
        bus.rx_data  = 8'hAA;
        bus.rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("hold_done", 32'(bus.done), 32'd1);
        checkOutput("hold_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("hold_nwrites", 32'(wr_data_log.size()), 32'd2);
        bus.rx_valid = 1'b0;

        // Gapped stream gives identical writes
        doReset();
        applyStimulus(basic_stream, 1'b1);
        waitTerminal();
        checkBasicWrites("gapped");
        checkOutput("gapped_done", 32'(bus.done), 32'd1);

`ifdef INST_LOADER_CHKSUM_EN
        // Bad checksum keeps the core in reset
        doReset();
        stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h08};
        applyStimulus(stream, 1'b0);
        waitTerminal();
        checkOutput("badchk_error", 32'(bus.error), 32'd1);
        checkOutput("badchk_done", 32'(bus.done), 32'd0);
        checkOutput("badchk_core_reset", 32'(bus.core_reset), 32'd1);
        checkOutput("badchk_rx_ready", 32'(bus.rx_ready), 32'd0);
`endif

        // Zero-length image
        doReset();
`ifdef INST_LOADER_CHKSUM_EN
        stream = '{8'h00, 8'h00, 8'h00};
`else
        stream = '{8'h00, 8'h00};
`endif
        applyStimulus(stream, 1'b0);
        waitTerminal();
        checkOutput("zero_done", 32'(bus.done), 32'd1);
        checkOutput("zero_nwrites", 32'(wr_data_log.size()), 32'd0);
        checkOutput("zero_core_reset", 32'(bus.core_reset), 32'd0);

        // Length 257 overflows a 256-word memory
        doReset();
        stream = '{8'h01, 8'h01};
        applyStimulus(stream, 1'b0);
        #1;
        checkOutput("ovf_error", 32'(bus.error), 32'd1);
        checkOutput("ovf_core_reset", 32'(bus.core_reset), 32'd1);
        checkOutput("ovf_rx_ready", 32'(bus.rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("ovf_nwrites", 32'(wr_data_log.size()), 32'd0);

        // Length 256 exactly fills memory and is accepted
        doReset();
        stream = '{8'h00, 8'h01};
        applyStimulus(stream, 1'b0);
        #1;
        checkOutput("full_len_error", 32'(bus.error), 32'd0);
        checkOutput("full_len_rx_ready", 32'(bus.rx_ready), 32'd1);

        // Reset after two payload bytes, then replay the whole image
        doReset();
        stream = '{8'h02, 8'h00, 8'h93, 8'h00};
        applyStimulus(stream, 1'b0);
        doReset();
        applyStimulus(basic_stream, 1'b0);
        waitTerminal();
        checkBasicWrites("midreset");
        checkOutput("midreset_done", 32'(bus.done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
